// File: rtl/instr_lane_reader_if.sv
// Bundles the arbiter write side, the pipeline read side and the lane status of
// instr_lane_reader. The reader sits on the slave modport; the arbiter/pipeline side uses master.
interface instr_lane_reader_if #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic             flush;
  logic             push1;
  logic             push2;
  logic [WIDTH-1:0] FIFO_1;
  logic [WIDTH-1:0] FIFO_2;
  logic             full1;
  logic             full2;
  logic             out1_valid;
  logic             out2_valid;
  logic [WIDTH-1:0] out1_instr;
  logic [WIDTH-1:0] out2_instr;
  logic             out1_ready;
  logic             out2_ready;
  logic [CntW-1:0]  count1;
  logic [CntW-1:0]  count2;
  logic             ovf1;
  logic             ovf2;

  modport master (
    output flush, push1, push2, FIFO_1, FIFO_2, out1_ready, out2_ready,
    input  full1, full2, out1_valid, out2_valid, out1_instr, out2_instr, count1, count2, ovf1, ovf2
  );

  modport slave (
    input  flush, push1, push2, FIFO_1, FIFO_2, out1_ready, out2_ready,
    output full1, full2, out1_valid, out2_valid, out1_instr, out2_instr, count1, count2, ovf1, ovf2
  );
endinterface

// File: rtl/instr_lane_reader.sv
// Two independent show-ahead instruction FIFOs feeding a dual-issue pipeline.
// Optional macro LANE_HAZARD_CHECK_EN stalls lane 2 when its head reads lane 1's head rd.
module instr_lane_reader #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input logic                 clk,
  input logic                 rst,
  instr_lane_reader_if.slave  bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [1:0]       w_push;
  logic [1:0]       w_ready;
  logic [1:0]       w_present;
  logic [1:0]       w_valid;
  logic [1:0]       w_ovf;
  logic [WIDTH-1:0] w_din   [2];
  logic [WIDTH-1:0] w_head  [2];
  logic [CntW-1:0]  w_count [2];
  logic             w_stall2;

  assign w_push   = {bus.push2, bus.push1};
  assign w_ready  = {bus.out2_ready, bus.out1_ready};
  assign w_din[0] = bus.FIFO_1;
  assign w_din[1] = bus.FIFO_2;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PtrW-1:0]  r_rd_ptr;
    logic [PtrW-1:0]  r_wr_ptr;
    logic [CntW-1:0]  r_cnt;
    logic             r_ovf;
    logic             w_full;
    logic             w_pop;
    logic             w_accept;

    assign w_full   = (r_cnt == FullCnt);
    assign w_pop    = w_valid[g] & w_ready[g];
    // A pop in the same cycle frees the slot, so a push while full still lands.
    assign w_accept = w_push[g] & (~w_full | w_pop);

    always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_cnt    <= '0;
        r_ovf    <= 1'b0;
      end else begin
        if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_accept && !w_pop) begin
          r_cnt <= r_cnt + 1'b1;
        end else if (!w_accept && w_pop) begin
          r_cnt <= r_cnt - 1'b1;
        end
        if (w_push[g] && !w_accept) r_ovf <= 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (w_accept && !rst && !bus.flush) r_mem[r_wr_ptr] <= w_din[g];
    end

    assign w_present[g] = (r_cnt != '0);
    assign w_head[g]    = r_mem[r_rd_ptr];
    assign w_count[g]   = r_cnt;
    assign w_ovf[g]     = r_ovf;
  end

`ifdef LANE_HAZARD_CHECK_EN
  logic [4:0] w_rd1;
  logic [4:0] w_rs1_2;
  logic [4:0] w_rs2_2;

  assign w_rd1    = w_head[0][4:0];
  assign w_rs1_2  = w_head[1][15:11];
  assign w_rs2_2  = w_head[1][20:16];
  // x0 is hardwired zero, so it can never carry a dependency.
  assign w_stall2 = w_present[0] && (w_rd1 != 5'd0) && ((w_rs1_2 == w_rd1) || (w_rs2_2 == w_rd1));
`else
  assign w_stall2 = 1'b0;
`endif

  assign w_valid = {w_present[1] & ~w_stall2, w_present[0]};

  assign bus.full1      = (w_count[0] == FullCnt);
  assign bus.full2      = (w_count[1] == FullCnt);
  assign bus.out1_valid = w_valid[0];
  assign bus.out2_valid = w_valid[1];
  assign bus.out1_instr = w_head[0];
  assign bus.out2_instr = w_head[1];
  assign bus.count1     = w_count[0];
  assign bus.count2     = w_count[1];
  assign bus.ovf1       = w_ovf[0];
  assign bus.ovf2       = w_ovf[1];
endmodule

// File: tb/tb_instr_lane_reader.sv
// Directed self-checking bench for instr_lane_reader (DEPTH=8, WIDTH=32).
module tb_instr_lane_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  instr_lane_reader_if #(.DEPTH(8), .WIDTH(32)) bus ();

  instr_lane_reader #(.DEPTH(8), .WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush      = 1'b0;
    bus.push1      = 1'b0;
    bus.push2      = 1'b0;
    bus.FIFO_1     = '0;
    bus.FIFO_2     = '0;
    bus.out1_ready = 1'b0;
    bus.out2_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_vec++;
    if (bus.full1 !== 1'b0 || bus.full2 !== 1'b0) begin
      n_err++; $display("FAIL reset_full got %b%b want 00", bus.full1, bus.full2);
    end
    n_vec++;
    if (bus.out1_valid !== 1'b0 || bus.out2_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_valid got %b%b want 00", bus.out1_valid, bus.out2_valid);
    end
    n_vec++;
    if (bus.count1 !== 4'd0 || bus.count2 !== 4'd0) begin
      n_err++; $display("FAIL reset_count got %0d/%0d want 0/0", bus.count1, bus.count2);
    end
    n_vec++;
    if (bus.ovf1 !== 1'b0 || bus.ovf2 !== 1'b0) begin
      n_err++; $display("FAIL reset_ovf got %b%b want 00", bus.ovf1, bus.ovf2);
    end
  endtask

  task automatic test_single_push();
    bus.push1  = 1'b1;
    bus.FIFO_1 = 32'h0004_5678;
    n_vec++;
    if (bus.out1_valid !== 1'b0) begin
      n_err++; $display("FAIL no_bypass out1_valid got %b want 0", bus.out1_valid);
    end
    step();
    bus.push1 = 1'b0;
    n_vec++;
    if (bus.out1_valid !== 1'b1 || bus.out1_instr !== 32'h0004_5678 || bus.count1 !== 4'd1) begin
      n_err++; $display("FAIL single_push got v=%b instr=%h cnt=%0d want v=1 instr=00045678 cnt=1",
                        bus.out1_valid, bus.out1_instr, bus.count1);
    end
    n_vec++;
    if (bus.out2_valid !== 1'b0) begin
      n_err++; $display("FAIL single_push_lane2 out2_valid got %b want 0", bus.out2_valid);
    end
    bus.out1_ready = 1'b1;
    step();
    step();  // ready held while empty must do nothing
    bus.out1_ready = 1'b0;
    n_vec++;
    if (bus.out1_valid !== 1'b0 || bus.count1 !== 4'd0) begin
      n_err++; $display("FAIL single_pop got v=%b cnt=%0d want v=0 cnt=0", bus.out1_valid, bus.count1);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) begin
      bus.push2  = 1'b1;
      bus.FIFO_2 = 32'h0000_0200 + i;
      step();
      if (i == 6) begin
        n_vec++;
        if (bus.full2 !== 1'b0 || bus.count2 !== 4'd7) begin
          n_err++; $display("FAIL ovf_7th got full=%b cnt=%0d want full=0 cnt=7", bus.full2, bus.count2);
        end
      end
      if (i == 7) begin
        n_vec++;
        if (bus.full2 !== 1'b1 || bus.ovf2 !== 1'b0 || bus.count2 !== 4'd8) begin
          n_err++; $display("FAIL ovf_8th got full=%b ovf=%b cnt=%0d want 1 0 8",
                            bus.full2, bus.ovf2, bus.count2);
        end
      end
    end
    bus.push2 = 1'b0;
    n_vec++;
    if (bus.ovf2 !== 1'b1 || bus.count2 !== 4'd8 || bus.full2 !== 1'b1) begin
      n_err++; $display("FAIL ovf_9th got ovf=%b cnt=%0d full=%b want 1 8 1",
                        bus.ovf2, bus.count2, bus.full2);
    end
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (bus.out2_valid !== 1'b1 || bus.out2_instr !== 32'h0000_0200 + i) begin
        n_err++; $display("FAIL ovf_pop%0d got v=%b instr=%h want v=1 instr=%h",
                          i, bus.out2_valid, bus.out2_instr, 32'h0000_0200 + i);
      end
      bus.out2_ready = 1'b1;
      step();
      bus.out2_ready = 1'b0;
    end
    n_vec++;
    if (bus.count2 !== 4'd0 || bus.out2_valid !== 1'b0 || bus.ovf2 !== 1'b1) begin
      n_err++; $display("FAIL ovf_drained got cnt=%0d v=%b ovf=%b want 0 0 1 (sticky)",
                        bus.count2, bus.out2_valid, bus.ovf2);
    end
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    n_vec++;
    if (bus.ovf2 !== 1'b0) begin
      n_err++; $display("FAIL ovf_flush_clear got ovf2=%b want 0", bus.ovf2);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 8; i++) begin
      bus.push1  = 1'b1;
      bus.FIFO_1 = 32'h0000_0100 + i;
      step();
    end
    bus.FIFO_1     = 32'h0000_ABCD;
    bus.out1_ready = 1'b1;
    step();
    bus.push1      = 1'b0;
    bus.out1_ready = 1'b0;
    n_vec++;
    if (bus.count1 !== 4'd8 || bus.ovf1 !== 1'b0 || bus.full1 !== 1'b1) begin
      n_err++; $display("FAIL full_push_pop got cnt=%0d ovf=%b full=%b want 8 0 1",
                        bus.count1, bus.ovf1, bus.full1);
    end
    for (int i = 0; i < 8; i++) begin
      logic [31:0] exp;
      exp = (i == 7) ? 32'h0000_ABCD : 32'h0000_0101 + i;
      n_vec++;
      if (bus.out1_valid !== 1'b1 || bus.out1_instr !== exp) begin
        n_err++; $display("FAIL wrap_pop%0d got v=%b instr=%h want v=1 instr=%h",
                          i, bus.out1_valid, bus.out1_instr, exp);
      end
      bus.out1_ready = 1'b1;
      step();
      bus.out1_ready = 1'b0;
    end
    n_vec++;
    if (bus.count1 !== 4'd0 || bus.out1_valid !== 1'b0) begin
      n_err++; $display("FAIL wrap_drained got cnt=%0d v=%b want 0 0", bus.count1, bus.out1_valid);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      bus.push1  = 1'b1;
      bus.FIFO_1 = 32'h0000_0300 + i;
      step();
    end
    n_vec++;
    if (bus.count1 !== 4'd3) begin
      n_err++; $display("FAIL flush_pre got cnt=%0d want 3", bus.count1);
    end
    bus.flush  = 1'b1;
    bus.FIFO_1 = 32'h0000_0399;
    step();
    bus.flush = 1'b0;
    bus.push1 = 1'b0;
    n_vec++;
    if (bus.count1 !== 4'd0 || bus.out1_valid !== 1'b0 || bus.ovf1 !== 1'b0) begin
      n_err++; $display("FAIL flush got cnt=%0d v=%b ovf=%b want 0 0 0",
                        bus.count1, bus.out1_valid, bus.ovf1);
    end
  endtask

  // Lane-1 head and lane-2 head pushed together; returns after one cycle of settling.
  task automatic load_pair(input logic [31:0] a, input logic [31:0] b);
    bus.push1  = 1'b1;
    bus.push2  = 1'b1;
    bus.FIFO_1 = a;
    bus.FIFO_2 = b;
    step();
    bus.push1 = 1'b0;
    bus.push2 = 1'b0;
  endtask

  task automatic test_hazard();
    // rd=21 in lane 1, rs1=21 in lane 2
    load_pair(32'h0000_0015, 32'h0000_A800);
    bus.out2_ready = 1'b1;
    step();
    bus.out2_ready = 1'b0;
`ifdef LANE_HAZARD_CHECK_EN
    n_vec++;
    if (bus.out2_valid !== 1'b0 || bus.count2 !== 4'd1) begin
      n_err++; $display("FAIL hazard_rs1_stall got v2=%b cnt2=%0d want 0 1", bus.out2_valid, bus.count2);
    end
    bus.out1_ready = 1'b1;
    step();
    bus.out1_ready = 1'b0;
    n_vec++;
    if (bus.out2_valid !== 1'b1 || bus.out2_instr !== 32'h0000_A800) begin
      n_err++; $display("FAIL hazard_resume got v2=%b instr=%h want 1 0000a800",
                        bus.out2_valid, bus.out2_instr);
    end
    bus.out2_ready = 1'b1;
    step();
    bus.out2_ready = 1'b0;
`else
    n_vec++;
    if (bus.count2 !== 4'd0 || bus.count1 !== 4'd1) begin
      n_err++; $display("FAIL indep_pop got cnt1=%0d cnt2=%0d want 1 0", bus.count1, bus.count2);
    end
    bus.out1_ready = 1'b1;
    step();
    bus.out1_ready = 1'b0;
`endif
    // rd=3 in lane 1, rs2=3 in lane 2
    load_pair(32'h0000_0003, 32'h0003_0000);
`ifdef LANE_HAZARD_CHECK_EN
    n_vec++;
    if (bus.out2_valid !== 1'b0) begin
      n_err++; $display("FAIL hazard_rs2_stall got v2=%b want 0", bus.out2_valid);
    end
`else
    n_vec++;
    if (bus.out2_valid !== 1'b1 || bus.out2_instr !== 32'h0003_0000) begin
      n_err++; $display("FAIL indep_valid got v2=%b instr=%h want 1 00030000",
                        bus.out2_valid, bus.out2_instr);
    end
`endif
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    // rd=0 never stalls, even though rs1=0 matches
    load_pair(32'h0000_0000, 32'h0000_0000);
    n_vec++;
    if (bus.out2_valid !== 1'b1 || bus.out1_valid !== 1'b1) begin
      n_err++; $display("FAIL hazard_x0 got v1=%b v2=%b want 1 1", bus.out1_valid, bus.out2_valid);
    end
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      load_pair(32'h0000_0400 + i, 32'h0000_0500 + i);
    end
    n_vec++;
    if (bus.count1 !== 4'd4 || bus.count2 !== 4'd4) begin
      n_err++; $display("FAIL rst_mid_pre got %0d/%0d want 4/4", bus.count1, bus.count2);
    end
    rst            = 1'b1;
    bus.out1_ready = 1'b1;
    bus.out2_ready = 1'b1;
    bus.push1      = 1'b1;
    bus.FIFO_1     = 32'h0000_0777;
    step();
    rst            = 1'b0;
    bus.out1_ready = 1'b0;
    bus.out2_ready = 1'b0;
    bus.push1      = 1'b0;
    n_vec++;
    if (bus.count1 !== 4'd0 || bus.count2 !== 4'd0 ||
        bus.out1_valid !== 1'b0 || bus.out2_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_mid got cnt=%0d/%0d v=%b%b want 0/0 00",
                        bus.count1, bus.count2, bus.out1_valid, bus.out2_valid);
    end
    bus.push1  = 1'b1;
    bus.FIFO_1 = 32'h0000_0888;
    step();
    bus.push1 = 1'b0;
    n_vec++;
    if (bus.out1_instr !== 32'h0000_0888 || bus.count1 !== 4'd1) begin
      n_err++; $display("FAIL rst_mid_after got instr=%h cnt=%0d want 00000888 1",
                        bus.out1_instr, bus.count1);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_push();
    test_overflow();
    test_full_push_pop();
    test_flush();
    test_hazard();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded 200000 time units");
    $fatal(1);
  end
endmodule
